// File: rtl/rom_boot_loader.sv
`timescale 1ns/1ps
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to the ROM
// port, holding CPU fetch off until done. Define ROM_LOADER_CKSUM_EN for a trailing checksum byte.
module rom_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wen_o,
    output logic        ren_o,
    output logic [31:0] w_addr_o,
    output logic [31:0] w_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle, StLen0, StLen1, StData, StWrite, StCksum, StErr
    } state_e;

    state_e      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_remaining;
    logic [1:0]  r_byte_idx;
    logic        r_ren;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_data;
`ifdef ROM_LOADER_CKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_xfer;
    logic [15:0] w_len;

    // Ready and write strobe are pure decodes of the state register.
    assign byte_ready_o = (r_state == StLen0) || (r_state == StLen1) ||
                          (r_state == StData) || (r_state == StCksum);
    assign wen_o        = (r_state == StWrite);
    assign w_xfer       = byte_valid_i & byte_ready_o;
    assign w_len        = {byte_data_i, r_len_lo};

    assign ren_o    = r_ren;
    assign w_addr_o = r_addr;
    assign w_data_o = r_data;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign err_o    = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_len_lo    <= 8'd0;
            r_remaining <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_ren       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_data      <= 32'd0;
`ifdef ROM_LOADER_CKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            case (r_state)
                StIdle, StErr: begin
                    if (start_i) begin
                        r_state     <= StLen0;
                        r_ren       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_addr      <= BASE_ADDR;
                        r_byte_idx  <= 2'd0;
                        r_remaining <= 16'd0;
`ifdef ROM_LOADER_CKSUM_EN
                        r_sum       <= 8'd0;
`endif
                    end
                end
                StLen0: begin
                    if (w_xfer) begin
                        r_len_lo <= byte_data_i;
                        r_state  <= StLen1;
                    end
                end
                StLen1: begin
                    if (w_xfer) begin
                        if (w_len == 16'd0) begin
`ifdef ROM_LOADER_CKSUM_EN
                            r_state <= StCksum;
`else
                            r_state <= StIdle;
                            r_ren   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else if (32'(w_len) > MAX_WORDS) begin
                            r_state <= StErr;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_remaining <= w_len;
                            r_state     <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_xfer) begin
                        r_data[8*r_byte_idx +: 8] <= byte_data_i;
                        r_byte_idx                <= r_byte_idx + 2'd1;
`ifdef ROM_LOADER_CKSUM_EN
                        r_sum                     <= r_sum + byte_data_i;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_state <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    r_addr      <= r_addr + 32'd4;
                    r_remaining <= r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
`ifdef ROM_LOADER_CKSUM_EN
                        r_state <= StCksum;
`else
                        r_state <= StIdle;
                        r_ren   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= StData;
                    end
                end
`ifdef ROM_LOADER_CKSUM_EN
                StCksum: begin
                    if (w_xfer) begin
                        if (byte_data_i == r_sum) begin
                            r_state <= StIdle;
                            r_ren   <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StErr;
                            r_err   <= 1'b1;
                        end
                        r_busy <= 1'b0;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
`timescale 1ns/1ps
// Randomised self-checking bench for rom_boot_loader against a stream/word-list reference model.
module tb_rom_boot_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 4;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o, wen_o, ren_o, busy_o, done_o, err_o;
    logic [31:0] w_addr_o, w_data_o;

    rom_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o), .wen_o(wen_o), .ren_o(ren_o),
        .w_addr_o(w_addr_o), .w_data_o(w_data_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          wen_cnt = 0;
    int          both_cnt = 0;
    int          long_cnt = 0;
    logic        prev_wen = 1'b0;
    logic [31:0] q_wa[$];
    logic [31:0] q_wd[$];
    logic [31:0] words[$];
    bit          stuck;

    // Write-port monitor
    always @(negedge clk) begin
        if (wen_o === 1'b1) begin
            q_wa.push_back(w_addr_o);
            q_wd.push_back(w_data_o);
            wen_cnt <= wen_cnt + 1;
        end
        if (wen_o === 1'b1 && ren_o === 1'b1) both_cnt <= both_cnt + 1;
        if (wen_o === 1'b1 && prev_wen === 1'b1) long_cnt <= long_cnt + 1;
        prev_wen <= wen_o;
    end

    // Reference stream: 16-bit count LSB first, words LE, then mod-256 byte sum if enabled.
    function automatic bq_t build_stream(input int hdr_n);
        bq_t s;
        int  sum = 0;
        s.push_back(hdr_n[7:0]);
        s.push_back(hdr_n[15:8]);
        if (hdr_n <= int'(MAXW)) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) begin
                    s.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
                    sum = sum + int'((words[i] >> (8 * k)) & 32'hFF);
                end
            end
`ifdef ROM_LOADER_CKSUM_EN
            s.push_back(8'(sum % 256));
`endif
        end
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stall);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready_o === 1'b1) begin
                @(posedge clk);
                #1;
                byte_valid_i = 1'b0;
                if (stall) begin
                    @(posedge clk);
                    #1;
                end
                return;
            end
        end
        stuck = 1'b1;
        byte_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_stream(input bq_t s, input bit stall);
        stuck = 1'b0;
        pulse_start();
        foreach (s[i]) send_byte(s[i], stall);
        for (int i = 0; i < 40; i++) begin
            if (busy_o === 1'b0) break;
            @(negedge clk);
        end
        if (busy_o !== 1'b0) stuck = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [70:0] exp_v;
        exp_v = {1'b0, 1'b0, 1'b1, BASE, 32'd0, 1'b0, 1'b0, 1'b0};
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({byte_ready_o, wen_o, ren_o, w_addr_o, w_data_o, busy_o, done_o, err_o} !== exp_v) begin
            $display("FAIL reset_values got=%h exp=%h",
                     {byte_ready_o, wen_o, ren_o, w_addr_o, w_data_o, busy_o, done_o, err_o}, exp_v);
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        n_total++;
        if ({byte_ready_o, wen_o, ren_o, w_addr_o, w_data_o, busy_o, done_o, err_o} !== exp_v) begin
            $display("FAIL idle_after_reset got=%h exp=%h",
                     {byte_ready_o, wen_o, ren_o, w_addr_o, w_data_o, busy_o, done_o, err_o}, exp_v);
        end else n_pass++;
    endtask

    task automatic test_load(input string name, input bit stall);
        int wb, cb;
        words = '{32'h0000_0013, 32'h0000_006F};
        wb = q_wa.size();
        cb = wen_cnt;
        run_stream(build_stream(2), stall);
        n_total++;
        if (stuck) $display("FAIL %s_timeout got=stuck exp=complete", name);
        else n_pass++;
        n_total++;
        if (wen_cnt - cb !== 2) $display("FAIL %s_wen_pulses got=%0d exp=2", name, wen_cnt - cb);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a, d;
            a = (wb + i < q_wa.size()) ? q_wa[wb + i] : 'x;
            d = (wb + i < q_wd.size()) ? q_wd[wb + i] : 'x;
            n_total++;
            if (a !== BASE + 32'(4 * i) || d !== words[i]) begin
                $display("FAIL %s_write%0d got=%h:%h exp=%h:%h", name, i, a, d,
                         BASE + 32'(4 * i), words[i]);
            end else n_pass++;
        end
        n_total++;
        if ({done_o, ren_o, err_o, busy_o} !== 4'b1100)
            $display("FAIL %s_status got=%b exp=1100", name, {done_o, ren_o, err_o, busy_o});
        else n_pass++;
    endtask

    task automatic test_oversize();
        int cb, wb;
        words = '{};
        cb = wen_cnt;
        run_stream(build_stream(5), 1'b0);
        n_total++;
        if ({err_o, ren_o, done_o, busy_o, byte_ready_o} !== 5'b10000 || stuck)
            $display("FAIL oversize_status got=%b exp=10000",
                     {err_o, ren_o, done_o, busy_o, byte_ready_o});
        else n_pass++;
        n_total++;
        if (wen_cnt !== cb) $display("FAIL oversize_no_write got=%0d exp=0", wen_cnt - cb);
        else n_pass++;
        // MAX_WORDS itself is accepted
        words = '{};
        for (int i = 0; i < int'(MAXW); i++) words.push_back($urandom);
        wb = q_wa.size();
        run_stream(build_stream(int'(MAXW)), 1'b0);
        n_total++;
        if ({done_o, ren_o, err_o} !== 3'b110 || stuck)
            $display("FAIL max_words_status got=%b exp=110", {done_o, ren_o, err_o});
        else n_pass++;
        n_total++;
        if (q_wa.size() - wb !== int'(MAXW) || q_wd[q_wd.size() - 1] !== words[MAXW - 1] ||
            q_wa[q_wa.size() - 1] !== BASE + 32'(4 * (MAXW - 1)))
            $display("FAIL max_words_writes got=%0d exp=%0d", q_wa.size() - wb, MAXW);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bq_t s;
        int  wb;
        logic [70:0] exp_v;
        exp_v = {1'b0, 1'b0, 1'b1, BASE, 32'd0, 1'b0, 1'b0, 1'b0};
        words = '{$urandom, $urandom};
        s = build_stream(2);
        stuck = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(s[i], 1'b0);
        n_total++;
        if ({ren_o, busy_o} !== 2'b01 || stuck)
            $display("FAIL mid_load_held got=%b exp=01", {ren_o, busy_o});
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({byte_ready_o, wen_o, ren_o, w_addr_o, w_data_o, busy_o, done_o, err_o} !== exp_v)
            $display("FAIL mid_reset_values got=%h exp=%h",
                     {byte_ready_o, wen_o, ren_o, w_addr_o, w_data_o, busy_o, done_o, err_o}, exp_v);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        words = '{$urandom};
        wb = q_wa.size();
        run_stream(build_stream(1), 1'b1);
        n_total++;
        if (q_wa.size() != wb + 1 || q_wa[wb] !== BASE || q_wd[wb] !== words[0] || !done_o)
            $display("FAIL reload_first_write got=%0d exp=1 write at %h data %h",
                     q_wa.size() - wb, BASE, words[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n, wb;
            bit stall;
            n = (it == 0) ? 0 : int'($urandom_range(1, MAXW));
            stall = bit'($urandom_range(0, 1));
            words = '{};
            for (int i = 0; i < n; i++) words.push_back($urandom);
            wb = q_wa.size();
            run_stream(build_stream(n), stall);
            n_total++;
            if (q_wa.size() - wb !== n || stuck)
                $display("FAIL rand%0d_count got=%0d exp=%0d", it, q_wa.size() - wb, n);
            else n_pass++;
            for (int i = 0; i < n; i++) begin
                logic [31:0] a, d;
                a = (wb + i < q_wa.size()) ? q_wa[wb + i] : 'x;
                d = (wb + i < q_wd.size()) ? q_wd[wb + i] : 'x;
                n_total++;
                if (a !== BASE + 32'(4 * i) || d !== words[i])
                    $display("FAIL rand%0d_write%0d got=%h:%h exp=%h:%h", it, i, a, d,
                             BASE + 32'(4 * i), words[i]);
                else n_pass++;
            end
            n_total++;
            if ({done_o, ren_o, err_o, busy_o} !== 4'b1100)
                $display("FAIL rand%0d_status got=%b exp=1100", it, {done_o, ren_o, err_o, busy_o});
            else n_pass++;
        end
    endtask

`ifdef ROM_LOADER_CKSUM_EN
    task automatic test_cksum();
        bq_t s;
        words = '{32'h0000_0013, 32'h0000_006F};
        s = build_stream(2);
        n_total++;
        if (s[s.size() - 1] !== 8'h82) $display("FAIL cksum_model got=%h exp=82", s[s.size() - 1]);
        else n_pass++;
        s[s.size() - 1] = 8'h83;
        run_stream(s, 1'b0);
        n_total++;
        if ({err_o, done_o, ren_o, busy_o} !== 4'b1000 || stuck)
            $display("FAIL cksum_bad got=%b exp=1000", {err_o, done_o, ren_o, busy_o});
        else n_pass++;
        words = '{};
        s = build_stream(0);
        run_stream(s, 1'b0);
        n_total++;
        if ({done_o, ren_o, err_o} !== 3'b110 || s.size() != 3 || stuck)
            $display("FAIL cksum_zero_len got=%b exp=110", {done_o, ren_o, err_o});
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load("basic", 1'b0);
        test_load("backpressure", 1'b1);
        test_oversize();
        test_reset_mid();
        test_random();
`ifdef ROM_LOADER_CKSUM_EN
        test_cksum();
`endif
        n_total++;
        if (both_cnt !== 0 || long_cnt !== 0)
            $display("FAIL wen_exclusive got=%0d/%0d exp=0/0", both_cnt, long_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
